// File: rtl/noc_inject_scheduler.sv
// noc_inject_scheduler: per-node injection scheduler sharing one PE-to-NoC
// port among N_REQ local packet sources. Round-robin grant, one registered
// output stage, injection-rate throttle and a packet budget with done flag.
// Optional macro INJECT_STALL_CNT_EN adds a saturating stall_cycles counter
// (cycles with r_valid_pe high and r_ready_pe low).
module noc_inject_scheduler #(
  parameter int N_REQ       = 4,
  parameter int X_SIZE      = 1,
  parameter int Y_SIZE      = 1,
  parameter int DATA_WIDTH  = 256,
  parameter int RATE        = 1,
  parameter int NUM_PACKETS = 10,
  parameter int CNT_WIDTH   = 32,
  localparam int TW         = X_SIZE + Y_SIZE + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*TW-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   r_valid_pe,
  output logic [TW-1:0]          r_data_pe,
  input  logic                   r_ready_pe,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic                   done
`ifdef INJECT_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   stall_cycles
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Gap counter only has to reach RATE-1; one bit suffices for RATE <= 2.
  localparam int GW = (RATE > 2) ? $clog2(RATE) : 1;
  localparam logic [GW-1:0]        GAP_MAX = GW'(RATE - 1);
  localparam logic [CNT_WIDTH:0]   BUDGET  = (CNT_WIDTH + 1)'(NUM_PACKETS);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_STOP  = 2'd2
  } state_t;

  state_t               state_p0;
  logic [PW-1:0]        ptr_p0;
  logic [GW-1:0]        gap_p0;
  logic                 thr_p0;

  logic                 hs;
  logic                 thr_ok;
  logic                 budget_ok;
  logic                 exhausted;
  logic                 room;
  logic                 any_req;
  logic                 cap;
  logic [CNT_WIDTH:0]   cnt_ext;
  logic [PW-1:0]        gnt;
  logic [PW-1:0]        idx;
  logic                 found;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Capture eligibility: room in the output stage, throttle, budget, any request.
  always_comb begin
    hs        = r_valid_pe & r_ready_pe;
    // A handshake this cycle restarts the throttle window; only RATE=1 may
    // capture in the very cycle of a handshake.
    thr_ok    = hs ? (RATE == 1) : thr_p0;
    cnt_ext   = {1'b0, pkt_count} + {{CNT_WIDTH{1'b0}}, hs};
    budget_ok = (NUM_PACKETS == 0) || (cnt_ext < BUDGET);
    exhausted = (NUM_PACKETS != 0) && (cnt_ext >= BUDGET);
    room      = (state_p0 == S_EMPTY) || ((state_p0 == S_FULL) && hs);
    any_req   = |req_valid;
    // rstn gates the accept pulse so no source sees req_ready while in reset.
    cap       = rstn & room & thr_ok & budget_ok & any_req;
  end

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr_p0) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    req_ready = cap ? (N_REQ'(1) << gnt) : '0;
  end

  // Output stage FSM: capture, hold until handshake, drain, stop on budget.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p0   <= S_EMPTY;
      r_valid_pe <= 1'b0;
      r_data_pe  <= '0;
      ptr_p0     <= '0;
      done       <= 1'b0;
    end else begin
      case (state_p0)
        S_EMPTY, S_FULL: begin
          if (cap) begin
            state_p0   <= S_FULL;
            r_valid_pe <= 1'b1;
            r_data_pe  <= req_data[int'(gnt)*TW +: TW];
            ptr_p0     <= PW'((int'(gnt) + 1) % N_REQ);
          end else if ((state_p0 == S_EMPTY) || hs) begin
            r_valid_pe <= 1'b0;
            if (exhausted) begin
              state_p0 <= S_STOP;
              done     <= 1'b1;
            end else begin
              state_p0 <= S_EMPTY;
            end
          end
        end
        S_STOP: begin
          r_valid_pe <= 1'b0;
          done       <= 1'b1;
        end
        default: begin
          state_p0   <= S_EMPTY;
          r_valid_pe <= 1'b0;
        end
      endcase
    end
  end

  // Handshake counter and throttle window tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count <= '0;
      gap_p0    <= '0;
      thr_p0    <= 1'b1;
    end else if (hs) begin
      pkt_count <= sat_inc(pkt_count);
      gap_p0    <= (RATE > 1) ? GW'(1) : '0;
      thr_p0    <= (RATE <= 2);
    end else if (!thr_p0) begin
      gap_p0    <= gap_p0 + 1'b1;
      thr_p0    <= ((gap_p0 + 1'b1) == GAP_MAX);
    end
  end

`ifdef INJECT_STALL_CNT_EN
  // Saturating count of cycles the NoC holds off a valid packet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (r_valid_pe && !r_ready_pe) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule
